// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer.
//   CH_A..CH_D : 2-bit channel codes (A = 0 ... D = 3)
//   NUM_CH     : number of output channels
//   state_t    : control FSM states
//   ch_onehot  : channel code to one-hot strobe (bit0 = A ... bit3 = D)
package demux_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALIGN = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_seq.sv
// Auto-rotation sequencer: channel pointer, wrap and frame_done strobe.
//   clk, reset  : clock, asynchronous active-low reset
//   enable      : when low the pointer is frozen (resync ignored)
//   auto_mode   : 1 = pointer advances on each transfer
//   xfer        : a sample is accepted this cycle
//   resync      : return the pointer to channel A
//   align       : FSM is in ALIGN, return the pointer to channel A
//   ptr         : current auto-mode channel
//   frame_done  : registered strobe, high the cycle after a sample lands in D
module demux_seq
    import demux_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       auto_mode,
    input  logic       xfer,
    input  logic       resync,
    input  logic       align,
    output logic [1:0] ptr,
    output logic       frame_done
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= CH_A;
            frame_done <= 1'b0;
        end else begin
            // In auto mode the sample goes to ptr, so a transfer with ptr at D
            // is the last sample of the frame, even if resync is also active.
            frame_done <= xfer && auto_mode && (ptr == CH_D);
            if (enable) begin
                if (align || resync)
                    ptr <= CH_A;
                else if (xfer && auto_mode)
                    ptr <= ptr + 2'd1;   // natural 2-bit wrap D -> A
            end
        end
    end

endmodule

// File: rtl/demultiplexer14.sv
// 1-to-4 demultiplexer with manual (S1,S2) or auto time-division routing.
//   clk, reset     : clock, asynchronous active-low reset
//   enable         : block enable; low forces IDLE and holds all state
//   mode           : 0 = manual routing, 1 = auto rotation
//   S1, S2         : manual channel select, S1 = MSB
//   resync         : force the auto pointer to channel A
//   X, x_valid     : input sample and its valid flag
//   x_ready        : combinational accept flag (enable and RUN)
//   A, B, C, D     : registered per-channel data
//   out_valid      : one-cycle strobe per channel (bit0 = A)
//   frame_done     : one-cycle strobe when auto mode fills channel D
//   sel_cur        : channel the next accepted sample routes to
module demultiplexer14
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             S1,
    input  logic             S2,
    input  logic             resync,
    input  logic [WIDTH-1:0] X,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    output logic             frame_done,
    output logic [1:0]       sel_cur
);

    state_t     state;
    logic       mode_p0;     // mode seen last enabled cycle, for change detection
    logic       xfer;
    logic [1:0] ptr;

    assign x_ready = enable && (state == RUN);
    assign xfer    = x_valid && x_ready;
    assign sel_cur = mode ? ptr : {S1, S2};

    demux_seq u_seq (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .auto_mode  (mode),
        .xfer       (xfer),
        .resync     (resync),
        .align      (state == ALIGN),
        .ptr        (ptr),
        .frame_done (frame_done)
    );

    // Control FSM: any mode change while running costs one ALIGN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mode_p0 <= 1'b0;
        end else if (!enable) begin
            state   <= IDLE;
        end else begin
            mode_p0 <= mode;
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (mode != mode_p0) state <= ALIGN;
                ALIGN:   state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage: only the selected channel loads; strobe lasts one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A         <= '0;
            B         <= '0;
            C         <= '0;
            D         <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= '0;
            if (xfer) begin
                out_valid <= ch_onehot(sel_cur);
                case (sel_cur)
                    CH_A:    A <= X;
                    CH_B:    B <= X;
                    CH_C:    C <= X;
                    default: D <= X;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demultiplexer14.sv
module tb_demultiplexer14;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, enable, mode, S1, S2, resync, x_valid;
    logic [W-1:0] X;
    logic         x_ready;
    logic [W-1:0] A, B, C, D;
    logic [3:0]   out_valid;
    logic         frame_done;
    logic [1:0]   sel_cur;

    always #5 clk = ~clk;

    demultiplexer14 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .S1(S1), .S2(S2), .resync(resync), .X(X), .x_valid(x_valid),
        .x_ready(x_ready), .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .frame_done(frame_done), .sel_cur(sel_cur)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: channel store, rotation index, phase number
    // (0 idle, 1 running, 2 realigning) and the last mode seen while enabled.
    logic [W-1:0] m_out [4];
    int           m_ptr;
    int           m_phase;
    logic         m_prev_mode;
    logic [3:0]   m_ov;
    logic         m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_ptr = 0; m_phase = 0; m_prev_mode = 1'b0; m_ov = '0; m_fd = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic md, input logic [1:0] s,
                              input logic rs, input logic [W-1:0] x, input logic xv);
        bit take;
        int ch;
        take = en && (m_phase == 1) && xv;
        ch   = md ? m_ptr : int'(s);
        m_ov = '0;
        m_fd = 1'b0;
        if (take) begin
            m_out[ch] = x;
            m_ov      = 4'(1 << ch);
            m_fd      = md && (ch == 3);
        end
        if (en) begin
            if (m_phase == 2 || rs) m_ptr = 0;
            else if (take && md)    m_ptr = (m_ptr + 1) % 4;
        end
        if (!en)               m_phase = 0;
        else if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) m_phase = (md != m_prev_mode) ? 2 : 1;
        else                   m_phase = 1;
        if (en) m_prev_mode = md;
    endtask

    task automatic check_regs();
        chk("A", 32'(A), 32'(m_out[0]));
        chk("B", 32'(B), 32'(m_out[1]));
        chk("C", 32'(C), 32'(m_out[2]));
        chk("D", 32'(D), 32'(m_out[3]));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: drive at negedge, check combinational outputs, then the edge.
    task automatic drive(input logic en, input logic md, input logic [1:0] s,
                         input logic rs, input logic [W-1:0] x, input logic xv,
                         output logic rdy_seen, output logic [1:0] sel_seen);
        @(negedge clk);
        enable = en; mode = md; {S1, S2} = s; resync = rs; X = x; x_valid = xv;
        #1;
        rdy_seen = x_ready;
        sel_seen = sel_cur;
        chk("x_ready", 32'(x_ready), 32'(en && (m_phase == 1)));
        chk("sel_cur", 32'(sel_cur), md ? 32'(m_ptr) : 32'(s));
        @(posedge clk);
        model_edge(en, md, s, rs, x, xv);
        #1;
        check_regs();
    endtask

    typedef struct {
        logic en, md; logic [1:0] s; logic rs; logic [W-1:0] x; logic xv;
        logic erdy; logic [1:0] esel;
        logic [W-1:0] ea, eb, ec, ed; logic [3:0] eov; logic efd;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic       r;
        logic [1:0] sl;
        logic       cur_md;

        //           en md s  rs x  xv  rdy sel  A  B  C  D  ov       fd
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 4'b0000, 0};
        tbl[1]  = '{1, 0, 2, 0, 1, 1,  1, 2,   0, 0, 1, 0, 4'b0100, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 0,  1, 1,   0, 0, 1, 0, 4'b0000, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0,  1, 0,   0, 0, 1, 0, 4'b0000, 0};
        tbl[4]  = '{1, 1, 0, 0, 1, 1,  0, 0,   0, 0, 1, 0, 4'b0000, 0};
        tbl[5]  = '{1, 1, 0, 0, 1, 1,  1, 0,   1, 0, 1, 0, 4'b0001, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 1,  1, 1,   1, 0, 1, 0, 4'b0010, 0};
        tbl[7]  = '{1, 1, 0, 0, 1, 1,  1, 2,   1, 0, 1, 0, 4'b0100, 0};
        tbl[8]  = '{1, 1, 0, 0, 1, 1,  1, 3,   1, 0, 1, 1, 4'b1000, 1};
        tbl[9]  = '{1, 1, 0, 0, 0, 0,  1, 0,   1, 0, 1, 1, 4'b0000, 0};
        tbl[10] = '{1, 1, 0, 0, 5, 1,  1, 0,   5, 0, 1, 1, 4'b0001, 0};
        tbl[11] = '{1, 1, 0, 0, 6, 1,  1, 1,   5, 6, 1, 1, 4'b0010, 0};
        tbl[12] = '{1, 1, 0, 1, 7, 1,  1, 2,   5, 6, 7, 1, 4'b0100, 0};
        tbl[13] = '{1, 1, 0, 0, 8, 1,  1, 0,   8, 6, 7, 1, 4'b0001, 0};
        tbl[14] = '{1, 0, 3, 0, 0, 0,  1, 3,   8, 6, 7, 1, 4'b0000, 0};
        tbl[15] = '{1, 0, 3, 0, 9, 1,  0, 3,   8, 6, 7, 1, 4'b0000, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0,  1, 0,   8, 6, 7, 1, 4'b0000, 0};
        tbl[17] = '{1, 1, 0, 0, 0, 0,  1, 0,   8, 6, 7, 1, 4'b0000, 0};
        tbl[18] = '{1, 1, 0, 0, 0, 0,  0, 0,   8, 6, 7, 1, 4'b0000, 0};
        tbl[19] = '{1, 1, 0, 0, 0, 0,  1, 0,   8, 6, 7, 1, 4'b0000, 0};
        tbl[20] = '{1, 1, 0, 0, 3, 1,  1, 0,   3, 6, 7, 1, 4'b0001, 0};
        tbl[21] = '{0, 1, 0, 0, 4, 1,  0, 1,   3, 6, 7, 1, 4'b0000, 0};
        tbl[22] = '{0, 1, 0, 1, 4, 1,  0, 1,   3, 6, 7, 1, 4'b0000, 0};
        tbl[23] = '{1, 1, 0, 0, 4, 1,  0, 1,   3, 6, 7, 1, 4'b0000, 0};
        tbl[24] = '{1, 1, 0, 0, 4, 1,  1, 1,   3, 4, 7, 1, 4'b0010, 0};

        // Reset state
        reset = 1'b0; enable = 1'b0; mode = 1'b0; S1 = 1'b0; S2 = 1'b0;
        resync = 1'b0; X = '0; x_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_A", 32'(A), 0);
        chk("rst_D", 32'(D), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_x_ready", 32'(x_ready), 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].en, tbl[i].md, tbl[i].s, tbl[i].rs, tbl[i].x, tbl[i].xv, r, sl);
            chk($sformatf("v%0d_rdy", i), 32'(r), 32'(tbl[i].erdy));
            chk($sformatf("v%0d_sel", i), 32'(sl), 32'(tbl[i].esel));
            chk($sformatf("v%0d_A", i), 32'(A), 32'(tbl[i].ea));
            chk($sformatf("v%0d_B", i), 32'(B), 32'(tbl[i].eb));
            chk($sformatf("v%0d_C", i), 32'(C), 32'(tbl[i].ec));
            chk($sformatf("v%0d_D", i), 32'(D), 32'(tbl[i].ed));
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("v%0d_fd", i), 32'(frame_done), 32'(tbl[i].efd));
        end

        // Reset asserted mid-transfer after two auto transfers
        drive(1, 1, 0, 1, 0, 0, r, sl);
        drive(1, 1, 0, 0, 2, 1, r, sl);
        drive(1, 1, 0, 0, 3, 1, r, sl);
        chk("pre_rst_A", 32'(A), 2);
        chk("pre_rst_B", 32'(B), 3);
        @(negedge clk);
        X = 4'd6; x_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_A", 32'(A), 0);
        chk("async_rst_B", 32'(B), 0);
        chk("async_rst_ov", 32'(out_valid), 0);
        chk("async_rst_fd", 32'(frame_done), 0);
        chk("async_rst_rdy", 32'(x_ready), 0);
        chk("async_rst_sel", 32'(sel_cur), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_A", 32'(A), 0);
        chk("rst_hold_ov", 32'(out_valid), 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        drive(1, 1, 0, 0, 5, 1, r, sl);
        chk("post_rst_idle_rdy", 32'(r), 0);
        drive(1, 1, 0, 0, 5, 1, r, sl);
        chk("post_rst_sel", 32'(sl), 0);
        chk("post_rst_A", 32'(A), 5);
        chk("post_rst_ov", 32'(out_valid), 1);

        // Randomized traffic against the reference model
        cur_md = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic en_r, rs_r, xv_r;
            logic [1:0] s_r;
            logic [W-1:0] x_r;
            if ($urandom_range(0, 15) == 0) cur_md = ~cur_md;
            en_r = ($urandom_range(0, 9) != 0);
            rs_r = ($urandom_range(0, 9) == 0);
            xv_r = ($urandom_range(0, 9) < 6);
            s_r  = 2'($urandom_range(0, 3));
            x_r  = W'($urandom);
            drive(en_r, cur_md, s_r, rs_r, x_r, xv_r, r, sl);
            chk("onehot_ov", 32'($countones(out_valid) <= 1), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
